// File: rtl/cci_mpf_prim_ram_dualport_be_init.sv
// Dual-port byte-enable RAM that self-initialises to INIT_VALUE after reset
// or a reinit pulse, with a valid-tagged, optionally deeper read pipeline.
module cci_mpf_prim_ram_dualport_be_init #(
   parameter int N_ENTRIES = 32,
   parameter int N_DATA_BITS = 64,
   parameter int N_LANES = 8,
   parameter int N_OUTPUT_REG_STAGES = 0,
   parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
   parameter int MIXED_BYPASS = 1,
   localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   reinit,
   output logic                   rdy,
   input  logic [AW-1:0]          addr0,
   input  logic                   wen0,
   input  logic [N_LANES-1:0]     wbe0,
   input  logic [N_DATA_BITS-1:0] wdata0,
   input  logic                   ren0,
   output logic                   rvalid0,
   output logic [N_DATA_BITS-1:0] rdata0,
   input  logic [AW-1:0]          addr1,
   input  logic                   wen1,
   input  logic [N_LANES-1:0]     wbe1,
   input  logic [N_DATA_BITS-1:0] wdata1,
   input  logic                   ren1,
   output logic                   rvalid1,
   output logic [N_DATA_BITS-1:0] rdata1
);

   localparam int DW = N_DATA_BITS;
   localparam int LW = DW / N_LANES;
   localparam int S = N_OUTPUT_REG_STAGES;
   localparam logic [AW-1:0] LAST = AW'(N_ENTRIES - 1);
   localparam logic [AW:0] NE = (AW + 1)'(N_ENTRIES);

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t state_q, state_d;
   logic [AW-1:0] init_addr_q, init_addr_d;
   logic [DW-1:0] mem [N_ENTRIES];

   logic in0, in1, we0, we1, same;
   logic [DW-1:0] old0, old1, wword0, wword1, base0, base1;
   logic [1:0] re;
   logic [DW-1:0] rword [2];

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] base,
                                           input logic [DW-1:0] wd,
                                           input logic [N_LANES-1:0] be);
      logic [DW-1:0] r;
      r = base;
      for (int i = 0; i < N_LANES; i++)
         if (be[i]) r[i*LW +: LW] = wd[i*LW +: LW];
      return r;
   endfunction

   assign rdy = (state_q == ST_READY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_INIT;
         init_addr_q <= '0;
      end else begin
         state_q <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      init_addr_d = init_addr_q;
      unique case (state_q)
         ST_INIT: begin
            if (init_addr_q == LAST) state_d = ST_READY;
            else init_addr_d = init_addr_q + 1'b1;
         end
         ST_READY: begin
            if (reinit) begin
               state_d = ST_INIT;
               init_addr_d = '0;
            end
         end
         default: ;
      endcase
   end

   assign in0 = {1'b0, addr0} < NE;
   assign in1 = {1'b0, addr1} < NE;
   assign we0 = rdy & wen0 & in0;
   assign we1 = rdy & wen1 & in1;
   assign same = (addr0 == addr1);
   assign old0 = in0 ? mem[addr0] : '0;
   assign old1 = in1 ? mem[addr1] : '0;

   // Port 0 merges on top of port 1 so it wins shared lanes
   assign wword1 = merge(old1, wdata1, wbe1);
   assign wword0 = merge((we1 && same) ? wword1 : old0, wdata0, wbe0);

   always_comb begin
      base0 = (MIXED_BYPASS != 0 && we1 && same) ? wword1 : old0;
      base1 = we1 ? wword1 : old1;
      rword[0] = we0 ? merge(base0, wdata0, wbe0) : base0;
      rword[1] = (MIXED_BYPASS != 0 && we0 && same) ?
                 merge(base1, wdata0, wbe0) : base1;
      if (!in0) rword[0] = '0;
      if (!in1) rword[1] = '0;
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[init_addr_q] <= INIT_VALUE;
      end else begin
         if (we1) mem[addr1] <= wword1;
         if (we0) mem[addr0] <= wword0;
      end
   end

   assign re = {rdy & ren1, rdy & ren0};

   logic [S:0] v_q [2];
   logic [DW-1:0] d_q [2][S+1];

   // Data stages only load on valid so the output holds between reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int p = 0; p < 2; p++) begin
            v_q[p] <= '0;
            for (int k = 0; k <= S; k++) d_q[p][k] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            v_q[p][0] <= re[p];
            if (re[p]) d_q[p][0] <= rword[p];
            for (int k = 1; k <= S; k++) begin
               v_q[p][k] <= v_q[p][k-1];
               if (v_q[p][k-1]) d_q[p][k] <= d_q[p][k-1];
            end
         end
      end
   end

   assign rvalid0 = v_q[0][S];
   assign rdata0 = d_q[0][S];
   assign rvalid1 = v_q[1][S];
   assign rdata1 = d_q[1][S];

endmodule
